// File: rtl/fcm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fcm_pkg
//  Description : Shared state encoding and default configuration for the
//                fabric clock frequency monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
package fcm_pkg;

    // Monitor state encoding
    typedef logic [1:0] fcm_state_t;

    localparam fcm_state_t IDLE    = 2'd0;
    localparam fcm_state_t ARM     = 2'd1;
    localparam fcm_state_t MEASURE = 2'd2;
    localparam fcm_state_t EVAL    = 2'd3;

    // Defaults: 100 MHz FAB_CLK measured over 32 periods of 32.768 kHz
    localparam int FCM_REF_PERIODS = 32;
    localparam int FCM_EXP_COUNT   = 97656;
    localparam int FCM_TOL         = 1000;
    localparam int FCM_LOCK_GOOD   = 4;
    localparam int FCM_CNT_W       = 20;

endpackage
`default_nettype wire

// File: rtl/fcm_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : fcm_sync_edge
//  Description : Two-flop synchronizer followed by a rising-edge detector.
//                Produces a one-cycle pulse in the clk domain for each rising
//                edge of the asynchronous input.
//  Ports       : clk      - destination clock
//                rst      - asynchronous active-high reset
//                async_in - asynchronous input
//                rise     - one-cycle pulse per rising edge
//  Revision    : 1.0 - initial release
// ============================================================================
module fcm_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rise = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/fab_clk_freq_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : fab_clk_freq_monitor
//  Description : Counts FAB_CLK cycles across REF_PERIODS reference periods,
//                compares the count against EXP_COUNT +/- TOL and raises LOCK
//                after LOCK_GOOD consecutive good windows.
//  Ports       : FAB_CLK    - sole clock
//                RESET      - asynchronous active-high reset
//                REF_CLK_IN - reference clock, asynchronous to FAB_CLK
//                ENABLE     - monitor run enable
//                LOCK       - frequency in tolerance for LOCK_GOOD windows
//                MEAS_VALID - one-cycle pulse when a window is published
//                MEAS_COUNT - cycle count of the last completed window
//                MEAS_GOOD  - last window within tolerance
//                REF_LOST   - no reference edge for 2^CNT_W-1 cycles (sticky
//                             until the next MEAS_VALID)
//  Options     : FCM_UNLOCK_HYST_EN - once locked, LOCK drops only after
//                UNLOCK_BAD consecutive bad windows.
//  Revision    : 1.0 - initial release
// ============================================================================
module fab_clk_freq_monitor
    import fcm_pkg::*;
#(
    parameter int REF_PERIODS = FCM_REF_PERIODS,
    parameter int EXP_COUNT   = FCM_EXP_COUNT,
    parameter int TOL         = FCM_TOL,
    parameter int LOCK_GOOD   = FCM_LOCK_GOOD,
    parameter int CNT_W       = FCM_CNT_W
`ifdef FCM_UNLOCK_HYST_EN
    ,
    parameter int UNLOCK_BAD  = 2
`endif
) (
    input  logic             FAB_CLK,
    input  logic             RESET,
    input  logic             REF_CLK_IN,
    input  logic             ENABLE,
    output logic             LOCK,
    output logic             MEAS_VALID,
    output logic [CNT_W-1:0] MEAS_COUNT,
    output logic             MEAS_GOOD,
    output logic             REF_LOST
);

    // edge_cnt only has to hold 0..REF_PERIODS-1: the final edge ends the
    // window instead of being stored.
    localparam int EDGE_W = (REF_PERIODS > 1) ? $clog2(REF_PERIODS) : 1;
    localparam int GOOD_W = $clog2(LOCK_GOOD + 1);

    localparam logic [EDGE_W-1:0] c_edge_last = EDGE_W'(REF_PERIODS - 1);
    localparam logic [EDGE_W-1:0] c_edge_one  = EDGE_W'(1);
    localparam logic [GOOD_W-1:0] c_good_max  = GOOD_W'(LOCK_GOOD);
    localparam logic [GOOD_W-1:0] c_good_one  = GOOD_W'(1);
    localparam logic [CNT_W-1:0]  c_cnt_max   = '1;
    localparam logic [CNT_W-1:0]  c_cnt_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  c_exp       = CNT_W'(EXP_COUNT);
    localparam logic [CNT_W-1:0]  c_tol       = CNT_W'(TOL);

`ifdef FCM_UNLOCK_HYST_EN
    localparam int BAD_W = $clog2(UNLOCK_BAD + 1);
    localparam logic [BAD_W-1:0] c_bad_max = BAD_W'(UNLOCK_BAD);
    localparam logic [BAD_W-1:0] c_bad_one = BAD_W'(1);
    logic [BAD_W-1:0] r_bad_cnt;
    logic [BAD_W-1:0] w_bad_next;
`endif

    fcm_state_t        r_state;
    logic [CNT_W-1:0]  r_cyc_cnt;
    logic [EDGE_W-1:0] r_edge_cnt;
    logic [GOOD_W-1:0] r_good_cnt;
    logic [CNT_W-1:0]  r_result;
    logic              r_lock;
    logic              r_meas_valid;
    logic [CNT_W-1:0]  r_meas_count;
    logic              r_meas_good;
    logic              r_ref_lost;

    logic              w_ref_rise;
    logic [CNT_W-1:0]  w_diff;
    logic              w_good;
    logic [GOOD_W-1:0] w_good_next;

    fcm_sync_edge u_sync_edge (
        .clk      (FAB_CLK),
        .rst      (RESET),
        .async_in (REF_CLK_IN),
        .rise     (w_ref_rise)
    );

    // Unsigned absolute deviation of the latched result from the target
    always_comb begin
        w_diff      = (r_result >= c_exp) ? (r_result - c_exp) : (c_exp - r_result);
        w_good      = (w_diff <= c_tol);
        w_good_next = (r_good_cnt == c_good_max) ? c_good_max : (r_good_cnt + c_good_one);
`ifdef FCM_UNLOCK_HYST_EN
        w_bad_next  = r_bad_cnt + c_bad_one;
`endif
    end

    always_ff @(posedge FAB_CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= IDLE;
            r_cyc_cnt    <= '0;
            r_edge_cnt   <= '0;
            r_good_cnt   <= '0;
            r_result     <= '0;
            r_lock       <= 1'b0;
            r_meas_valid <= 1'b0;
            r_meas_count <= '0;
            r_meas_good  <= 1'b0;
            r_ref_lost   <= 1'b0;
`ifdef FCM_UNLOCK_HYST_EN
            r_bad_cnt    <= '0;
`endif
        end else begin
            r_meas_valid <= 1'b0;
            if (!ENABLE) begin
                // Abort: measurement results are kept, lock history is not
                r_state    <= IDLE;
                r_cyc_cnt  <= '0;
                r_edge_cnt <= '0;
                r_good_cnt <= '0;
                r_lock     <= 1'b0;
                r_ref_lost <= 1'b0;
`ifdef FCM_UNLOCK_HYST_EN
                r_bad_cnt  <= '0;
`endif
            end else begin
                case (r_state)
                    IDLE: begin
                        r_cyc_cnt  <= '0;
                        r_edge_cnt <= '0;
                        r_state    <= ARM;
                    end
                    ARM, MEASURE: begin
                        if (r_state == ARM && w_ref_rise) begin
                            // Start edge: counting restarts from 0 next cycle
                            r_cyc_cnt  <= '0;
                            r_edge_cnt <= '0;
                            r_state    <= MEASURE;
                        end else if (r_cyc_cnt == c_cnt_max) begin
                            // Reference absent for a full counter span
                            r_ref_lost <= 1'b1;
                            r_lock     <= 1'b0;
                            r_good_cnt <= '0;
                            r_cyc_cnt  <= '0;
                            r_edge_cnt <= '0;
                            r_state    <= ARM;
`ifdef FCM_UNLOCK_HYST_EN
                            r_bad_cnt  <= '0;
`endif
                        end else if (r_state == MEASURE && w_ref_rise &&
                                     r_edge_cnt == c_edge_last) begin
                            // cyc_cnt lags the edge distance by one cycle
                            r_result <= r_cyc_cnt + c_cnt_one;
                            r_state  <= EVAL;
                        end else begin
                            r_cyc_cnt <= r_cyc_cnt + c_cnt_one;
                            if (r_state == MEASURE && w_ref_rise) begin
                                r_edge_cnt <= r_edge_cnt + c_edge_one;
                            end
                        end
                    end
                    EVAL: begin
                        r_meas_count <= r_result;
                        r_meas_valid <= 1'b1;
                        r_meas_good  <= w_good;
                        r_ref_lost   <= 1'b0;
                        r_cyc_cnt    <= '0;
                        r_edge_cnt   <= '0;
                        r_state      <= ARM;
`ifdef FCM_UNLOCK_HYST_EN
                        if (w_good) begin
                            r_good_cnt <= w_good_next;
                            r_lock     <= (w_good_next == c_good_max);
                            r_bad_cnt  <= '0;
                        end else if (r_lock && (w_bad_next != c_bad_max)) begin
                            // Tolerated bad window: keep lock and good history
                            r_bad_cnt <= w_bad_next;
                        end else begin
                            r_good_cnt <= '0;
                            r_lock     <= 1'b0;
                            r_bad_cnt  <= '0;
                        end
`else
                        if (w_good) begin
                            r_good_cnt <= w_good_next;
                            r_lock     <= (w_good_next == c_good_max);
                        end else begin
                            r_good_cnt <= '0;
                            r_lock     <= 1'b0;
                        end
`endif
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign LOCK       = r_lock;
    assign MEAS_VALID = r_meas_valid;
    assign MEAS_COUNT = r_meas_count;
    assign MEAS_GOOD  = r_meas_good;
    assign REF_LOST   = r_ref_lost;

endmodule
`default_nettype wire
